decode_stage_pipe: RTL and testbench

Parametrised, registered instruction-decode stage for the pipelined RISC CPU, sitting between the fetch stage and the execute stage. It splits each instruction into opcode and register/immediate/address fields, drives the register-file read ports and builds operands with write-back bypass. Results are held in an ID/EX pipeline register behind a valid/ready handshake. It detects load-use hazards and inserts one bubble, and it supports pipeline flush and illegal-opcode flagging.

---
 rtl/decode_stage_pipe.sv | 165 ++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: instruction decode with register-file read, write-back
// bypass, a single ID/EX register behind valid/ready, load-use bubble
// insertion, flush and illegal-opcode flagging.
module decode_stage_pipe #(
  parameter int DATA_W       = 16,
  parameter int REG_W        = 4,
  parameter int SIGN_EXT_IMM = 0,
  localparam int INSTR_W     = 4 + 3*REG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  input  logic               flush,
  output logic [REG_W-1:0]   rs1_addr,
  output logic [REG_W-1:0]   rs2_addr,
  input  logic [DATA_W-1:0]  rs1_data,
  input  logic [DATA_W-1:0]  rs2_data,
  input  logic               wb_we,
  input  logic [REG_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_opcode,
  output logic [DATA_W-1:0]  out_op1,
  output logic [DATA_W-1:0]  out_op2,
  output logic [REG_W-1:0]   out_rd,
  output logic               out_we,
  output logic               out_store,
  output logic               out_load,
  output logic [REG_W-1:0]   out_mem_addr,
  output logic               out_illegal,
  output logic               hazard
);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_LOADI = 4'd3;
  localparam logic [3:0] OP_STORE = 4'd4;
  localparam logic [3:0] OP_LOADM = 4'd5;

  typedef struct packed {
    logic [3:0]        opcode;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  mem_addr;
    logic              we;
    logic              store;
    logic              load;
    logic              illegal;
  } idex_t;

  logic [3:0]        opc;
  logic [REG_W-1:0]  fa, fb, fc;
  logic [DATA_W-1:0] imm, src1_val, src2_val;
  logic              use1, use2, accept, vld;
  idex_t             dec, idex;

  assign opc = in_instr[INSTR_W-1 -: 4];
  assign fa  = in_instr[3*REG_W-1 -: REG_W];
  assign fb  = in_instr[2*REG_W-1 -: REG_W];
  assign fc  = in_instr[REG_W-1:0];

  if (SIGN_EXT_IMM != 0) begin : g_sext
    assign imm = {{(DATA_W-REG_W){fb[REG_W-1]}}, fb};
  end else begin : g_zext
    assign imm = {{(DATA_W-REG_W){1'b0}}, fb};
  end

  // Register-file read addresses and source-use flags from the raw fields
  always_comb begin
    rs1_addr = '0;
    rs2_addr = '0;
    use1     = 1'b0;
    use2     = 1'b0;
    case (opc)
      OP_ADD, OP_SUB: begin
        rs1_addr = fb;
        rs2_addr = fc;
        use1     = 1'b1;
        use2     = 1'b1;
      end
      OP_STORE: begin
        rs1_addr = fa;
        use1     = 1'b1;
      end
      default: ;
    endcase
  end

  // Write-back bypass: a same-cycle write to a source beats the file data
  assign src1_val = (wb_we && wb_addr == rs1_addr) ? wb_data : rs1_data;
  assign src2_val = (wb_we && wb_addr == rs2_addr) ? wb_data : rs2_data;

  // Decoded ID/EX payload; undefined opcodes collapse to a flagged NOP
  always_comb begin
    dec = '0;
    case (opc)
      OP_NOP: ;
      OP_ADD, OP_SUB: begin
        dec.opcode = opc;
        dec.rd     = fa;
        dec.op1    = src1_val;
        dec.op2    = src2_val;
        dec.we     = 1'b1;
      end
      OP_LOADI: begin
        dec.opcode = opc;
        dec.rd     = fa;
        dec.op1    = imm;
        dec.we     = 1'b1;
      end
      OP_STORE: begin
        dec.opcode   = opc;
        dec.op1      = src1_val;
        dec.mem_addr = fb;
        dec.store    = 1'b1;
      end
      OP_LOADM: begin
        dec.opcode   = opc;
        dec.rd       = fa;
        dec.mem_addr = fb;
        dec.load     = 1'b1;
        dec.we       = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Load-use: the load in ID/EX has not produced data yet, so stall one cycle
  assign hazard = vld && idex.load && in_valid &&
                  ((use1 && rs1_addr == idex.rd) || (use2 && rs2_addr == idex.rd));
  assign in_ready = !flush && !hazard && (!vld || out_ready);
  assign accept   = in_valid && in_ready;

  // ID/EX register: flush > accept > drain; operands are frozen while held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      idex <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (accept) begin
      vld  <= 1'b1;
      idex <= dec;
    end else if (out_ready) begin
      vld <= 1'b0;
    end
  end

  assign out_valid    = vld;
  assign out_opcode   = idex.opcode;
  assign out_op1      = idex.op1;
  assign out_op2      = idex.op2;
  assign out_rd       = idex.rd;
  assign out_mem_addr = idex.mem_addr;
  assign out_we       = vld && idex.we;
  assign out_store    = vld && idex.store;
  assign out_load     = vld && idex.load;
  assign out_illegal  = vld && idex.illegal;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios then random traffic, all
// checked against an opcode-table reference model of the ID/EX register.
module tb_decode_stage_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default-width DUT
  logic        in_valid, in_ready, flush, wb_we, out_valid, out_ready;
  logic [15:0] in_instr, rs1_data, rs2_data, wb_data, out_op1, out_op2;
  logic [3:0]  rs1_addr, rs2_addr, wb_addr, out_opcode, out_rd, out_mem_addr;
  logic        out_we, out_store, out_load, out_illegal, hazard;

  logic [15:0] rf [16];
  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  decode_stage_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .flush(flush), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
    .out_we(out_we), .out_store(out_store), .out_load(out_load),
    .out_mem_addr(out_mem_addr), .out_illegal(out_illegal), .hazard(hazard)
  );

  // wide, sign-extending DUT
  logic        w_in_valid, w_in_ready, w_flush, w_wb_we, w_out_valid, w_out_ready;
  logic [18:0] w_in_instr;
  logic [4:0]  w_rs1_addr, w_rs2_addr, w_wb_addr, w_out_rd, w_out_mem_addr;
  logic [31:0] w_rs1_data, w_rs2_data, w_wb_data, w_out_op1, w_out_op2;
  logic [3:0]  w_out_opcode;
  logic        w_out_we, w_out_store, w_out_load, w_out_illegal, w_hazard;

  decode_stage_pipe #(.DATA_W(32), .REG_W(5), .SIGN_EXT_IMM(1)) u_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_instr(w_in_instr),
    .in_ready(w_in_ready), .flush(w_flush), .rs1_addr(w_rs1_addr), .rs2_addr(w_rs2_addr),
    .rs1_data(w_rs1_data), .rs2_data(w_rs2_data), .wb_we(w_wb_we), .wb_addr(w_wb_addr),
    .wb_data(w_wb_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_opcode(w_out_opcode), .out_op1(w_out_op1), .out_op2(w_out_op2), .out_rd(w_out_rd),
    .out_we(w_out_we), .out_store(w_out_store), .out_load(w_out_load),
    .out_mem_addr(w_out_mem_addr), .out_illegal(w_out_illegal), .hazard(w_hazard)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference view of one decoded instruction
  typedef struct {
    logic [3:0]  opcode;
    logic [15:0] op1, op2;
    logic [3:0]  rd, ma, rs1, rs2;
    logic        we, st, ld, ill, u1, u2;
    logic        k_op1, k_op2, k_rd, k_ma;  // which payload fields are defined
  } exp_t;

  exp_t m;          // held ID/EX contents
  logic m_valid;
  logic obs_hz, obs_rdy;
  logic [3:0] obs_rs1, obs_rs2;

  function automatic logic [15:0] rd_src(input logic [3:0] s, input logic bwe,
                                         input logic [3:0] ba, input logic [15:0] bd);
    return (bwe && ba == s) ? bd : rf[s];
  endfunction

  function automatic exp_t model(input logic [15:0] ins, input logic bwe,
                                 input logic [3:0] ba, input logic [15:0] bd);
    exp_t e;
    int op;
    logic [3:0] a, b, c;
    op = int'(ins[15:12]);
    a = ins[11:8]; b = ins[7:4]; c = ins[3:0];
    e = '{default: '0};
    if (op >= 6) e.ill = 1'b1;
    else e.opcode = ins[15:12];
    if (op == 1 || op == 2) begin
      e.rd = a; e.rs1 = b; e.rs2 = c; e.u1 = 1; e.u2 = 1; e.we = 1;
      e.op1 = rd_src(b, bwe, ba, bd); e.op2 = rd_src(c, bwe, ba, bd);
      e.k_op1 = 1; e.k_op2 = 1; e.k_rd = 1;
    end else if (op == 3) begin
      e.rd = a; e.op1 = {12'd0, b}; e.op2 = 16'd0; e.we = 1;
      e.k_op1 = 1; e.k_op2 = 1; e.k_rd = 1;
    end else if (op == 4) begin
      e.rs1 = a; e.u1 = 1; e.op1 = rd_src(a, bwe, ba, bd); e.ma = b; e.st = 1;
      e.k_op1 = 1; e.k_ma = 1;
    end else if (op == 5) begin
      e.rd = a; e.ma = b; e.ld = 1; e.we = 1; e.k_rd = 1; e.k_ma = 1;
    end
    return e;
  endfunction

  // One cycle: drive at negedge, check combinational outputs, clock, check ID/EX.
  task automatic step(input logic iv, input logic [15:0] ins, input logic ordy,
                      input logic fl, input logic bwe, input logic [3:0] ba,
                      input logic [15:0] bd);
    exp_t d;
    logic ehz, erdy;
    in_valid = iv; in_instr = ins; out_ready = ordy; flush = fl;
    wb_we = bwe; wb_addr = ba; wb_data = bd;
    #1;
    d    = model(ins, bwe, ba, bd);
    ehz  = m_valid && m.ld && iv && ((d.u1 && d.rs1 == m.rd) || (d.u2 && d.rs2 == m.rd));
    erdy = !fl && !ehz && (!m_valid || ordy);
    obs_hz = hazard; obs_rdy = in_ready; obs_rs1 = rs1_addr; obs_rs2 = rs2_addr;
    chk("hazard", 64'(hazard), 64'(ehz));
    chk("in_ready", 64'(in_ready), 64'(erdy));
    chk("rs1_addr", 64'(rs1_addr), 64'(d.rs1));
    chk("rs2_addr", 64'(rs2_addr), 64'(d.rs2));
    @(posedge clk);
    if (bwe) rf[ba] = bd;
    if (fl) m_valid = 1'b0;
    else if (iv && erdy) begin m = d; m_valid = 1'b1; end
    else if (ordy) m_valid = 1'b0;
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_we", 64'(out_we), 64'(m_valid && m.we));
    chk("out_store", 64'(out_store), 64'(m_valid && m.st));
    chk("out_load", 64'(out_load), 64'(m_valid && m.ld));
    chk("out_illegal", 64'(out_illegal), 64'(m_valid && m.ill));
    if (m_valid) begin
      chk("out_opcode", 64'(out_opcode), 64'(m.opcode));
      if (m.k_op1) chk("out_op1", 64'(out_op1), 64'(m.op1));
      if (m.k_op2) chk("out_op2", 64'(out_op2), 64'(m.op2));
      if (m.k_rd)  chk("out_rd", 64'(out_rd), 64'(m.rd));
      if (m.k_ma)  chk("out_mem_addr", 64'(out_mem_addr), 64'(m.ma));
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] op;
    for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
    m = '{default: '0}; m_valid = 1'b0;
    rst_n = 1'b0;
    in_valid = 0; in_instr = '0; flush = 0; out_ready = 0; wb_we = 0; wb_addr = '0; wb_data = '0;
    w_in_valid = 0; w_in_instr = '0; w_flush = 0; w_out_ready = 0; w_wb_we = 0;
    w_wb_addr = '0; w_wb_data = '0; w_rs1_data = 32'h1234_5678; w_rs2_data = 32'h9abc_def0;

    // reset state
    #3;
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst out_opcode", 64'(out_opcode), 64'(0));
    chk("rst out_op1", 64'(out_op1), 64'(0));
    chk("rst out_op2", 64'(out_op2), 64'(0));
    chk("rst out_rd", 64'(out_rd), 64'(0));
    chk("rst out_mem_addr", 64'(out_mem_addr), 64'(0));
    chk("rst enables", 64'({out_we, out_store, out_load, out_illegal}), 64'(0));
    chk("rst in_ready", 64'(in_ready), 64'(1));
    chk("rst wide out_valid", 64'(w_out_valid), 64'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // LOADI r0 <- 2
    step(1, 16'h3020, 1, 0, 0, 4'd0, 16'd0);
    chk("loadi valid", 64'(out_valid), 64'(1));
    chk("loadi rd", 64'(out_rd), 64'(0));
    chk("loadi op1", 64'(out_op1), 64'(2));
    chk("loadi we", 64'(out_we), 64'(1));

    // ADD r1 = r2 + r3 with write-back bypass on r3
    rf[2] = 16'd5; rf[3] = 16'd8;
    step(1, 16'h1123, 1, 0, 1, 4'd3, 16'd20);
    chk("add rs1_addr", 64'(obs_rs1), 64'(2));
    chk("add rs2_addr", 64'(obs_rs2), 64'(3));
    chk("add op1", 64'(out_op1), 64'(5));
    chk("add op2 bypass", 64'(out_op2), 64'(20));
    chk("add rd", 64'(out_rd), 64'(1));

    // load-use: LOADM r4, then ADD reading r4
    step(1, 16'h5410, 1, 0, 0, 4'd0, 16'd0);
    step(1, 16'h1240, 1, 0, 0, 4'd0, 16'd0);
    chk("lu hazard", 64'(obs_hz), 64'(1));
    chk("lu bubble", 64'(out_valid), 64'(0));
    step(1, 16'h1240, 1, 0, 0, 4'd0, 16'd0);
    chk("lu hazard cleared", 64'(obs_hz), 64'(0));
    chk("lu add issued", 64'({out_valid, out_opcode}), 64'({1'b1, 4'd1}));

    // backpressure on a held SUB
    step(1, 16'h2123, 1, 0, 0, 4'd0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, 16'h3055, 0, 0, 1, 4'd1, 16'hbeef);
      chk("bp in_ready", 64'(obs_rdy), 64'(0));
      chk("bp held opcode", 64'(out_opcode), 64'(2));
    end
    step(1, 16'h3055, 1, 0, 0, 4'd0, 16'd0);
    chk("bp release accept", 64'(obs_rdy), 64'(1));
    chk("bp next opcode", 64'(out_opcode), 64'(3));

    // flush with in_valid
    step(1, 16'h1111, 1, 1, 0, 4'd0, 16'd0);
    chk("flush in_ready", 64'(obs_rdy), 64'(0));
    chk("flush out_valid", 64'(out_valid), 64'(0));

    // illegal opcode
    step(1, 16'hF123, 1, 0, 0, 4'd0, 16'd0);
    chk("ill flag", 64'(out_illegal), 64'(1));
    chk("ill opcode", 64'(out_opcode), 64'(0));
    chk("ill enables", 64'({out_we, out_store, out_load}), 64'(0));

    // asynchronous reset while holding
    out_ready = 0;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 64'(out_valid), 64'(0));
    chk("async rst illegal", 64'(out_illegal), 64'(0));
    m = '{default: '0}; m_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic, small register range to provoke hazards and bypass hits
    for (int n = 0; n < 400; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'(5) : 4'($urandom_range(0, 15));
      step($urandom_range(0, 9) < 7,
           {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           1'($urandom), 4'($urandom_range(0, 3)), 16'($urandom));
    end
    in_valid = 0; out_ready = 1;

    // wide instance: sign-extended LOADI immediate
    w_in_instr = {4'b0011, 5'd0, 5'b11110, 5'd0};
    w_in_valid = 1; w_out_ready = 1;
    @(posedge clk); #1;
    chk("wide valid", 64'(w_out_valid), 64'(1));
    chk("wide sext op1", 64'(w_out_op1), 64'(32'hFFFF_FFFE));
    chk("wide we", 64'(w_out_we), 64'(1));
    @(negedge clk);
    w_in_valid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
